// File: rtl/des_key_if.sv
// Handshake bundle between the key register file, the DES key schedule and the round datapath.
interface des_key_if;
  logic        start;
  logic        mode;
  logic [63:0] key_in;
  logic        abort;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        parity_err;

  modport master (
    output start, mode, key_in, abort, subkey_ready,
    input  subkey_valid, subkey, round_idx, busy, done, parity_err
  );

  modport slave (
    input  start, mode, key_in, abort, subkey_ready,
    output subkey_valid, subkey, round_idx, busy, done, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on start, then one PC-2 round subkey per handshake,
// in encrypt (K1..K16) or decrypt (K16..K1) order, with optional odd-parity check.
module des_key_schedule #(
  parameter logic [15:0] SHIFT1_MASK  = 16'h8103,
  parameter bit          PIPE_OUT     = 1'b0,
  parameter bit          CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  des_key_if.slave   kif
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned IDX_W  = 4;

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Table entries use DES numbering: bit 1 is the MSB of the packed vector.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[6'(55 - j)] = k[6'(64 - PC1_TAB[j])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
    return r;
  endfunction

  // C and D halves rotate independently.
  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd, input logic left,
                                             input logic one);
    logic [HALF_W-1:0] c, d;
    c = cd[CD_W-1:HALF_W];
    d = cd[HALF_W-1:0];
    if (left) begin
      c = one ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
      d = one ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
    end else begin
      c = one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
      d = one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
    end
    return {c, d};
  endfunction

  function automatic logic par_err(input logic [KEY_W-1:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) e = e | ~(^k[6'(b * 8) +: 8]);
    return e;
  endfunction

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               src_avail_q, src_avail_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               obuf_valid_q, obuf_valid_d;
  logic [SK_W-1:0]    obuf_key_q, obuf_key_d;
  logic [IDX_W-1:0]   obuf_idx_q, obuf_idx_d;

  logic [SK_W-1:0]    sk_c;
  logic               out_valid_c;
  logic [IDX_W-1:0]   out_idx_c;
  logic               accept_c;
  logic               advance_c;
  logic               last_c;

  assign sk_c        = pc2(cd_q);
  assign out_valid_c = PIPE_OUT ? obuf_valid_q : (state_q == RUN);
  assign out_idx_c   = PIPE_OUT ? obuf_idx_q : idx_q;
  assign accept_c    = out_valid_c & kif.subkey_ready;
  assign last_c      = accept_c & (out_idx_c == 4'd15);
  // The CD register steps on consumer accept, or on buffer (re)load when buffered.
  assign advance_c   = PIPE_OUT ? ((state_q == RUN) & src_avail_q & (~obuf_valid_q | accept_c))
                                : ((state_q == RUN) & accept_c);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cd_d         = cd_q;
    idx_d        = idx_q;
    src_avail_d  = src_avail_q;
    done_d       = 1'b0;
    perr_d       = perr_q;
    obuf_valid_d = obuf_valid_q;
    obuf_key_d   = obuf_key_q;
    obuf_idx_d   = obuf_idx_q;

    case (state_q)
      IDLE: begin
        if (kif.start) begin
          state_d      = RUN;
          mode_d       = kif.mode;
          cd_d         = kif.mode ? pc1(kif.key_in) : rot_cd(pc1(kif.key_in), 1'b1, SHIFT1_MASK[0]);
          idx_d        = '0;
          src_avail_d  = 1'b1;
          obuf_valid_d = 1'b0;
          perr_d       = CHECK_PARITY ? par_err(kif.key_in) : 1'b0;
        end
      end
      RUN: begin
        if (kif.abort) begin
          state_d      = IDLE;
          src_avail_d  = 1'b0;
          obuf_valid_d = 1'b0;
        end else begin
          // Decrypt walks CD backwards: undo the shift that produced the current round.
          if (advance_c && idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
            cd_d  = rot_cd(cd_q, ~mode_q,
                           mode_q ? SHIFT1_MASK[4'd15 - idx_q] : SHIFT1_MASK[idx_q + 4'd1]);
          end
          if (advance_c && idx_q == 4'd15) src_avail_d = 1'b0;
          if (PIPE_OUT) begin
            if (advance_c) begin
              obuf_valid_d = 1'b1;
              obuf_key_d   = sk_c;
              obuf_idx_d   = idx_q;
            end else if (accept_c) begin
              obuf_valid_d = 1'b0;
            end
          end
          if (last_c) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            src_avail_d  = 1'b0;
            obuf_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      cd_q         <= '0;
      idx_q        <= '0;
      src_avail_q  <= 1'b0;
      done_q       <= 1'b0;
      perr_q       <= 1'b0;
      obuf_valid_q <= 1'b0;
      obuf_key_q   <= '0;
      obuf_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cd_q         <= cd_d;
      idx_q        <= idx_d;
      src_avail_q  <= src_avail_d;
      done_q       <= done_d;
      perr_q       <= perr_d;
      obuf_valid_q <= obuf_valid_d;
      obuf_key_q   <= obuf_key_d;
      obuf_idx_q   <= obuf_idx_d;
    end
  end

  assign kif.subkey_valid = out_valid_c;
  assign kif.subkey       = PIPE_OUT ? obuf_key_q : sk_c;
  assign kif.round_idx    = out_idx_c;
  assign kif.busy         = (state_q == RUN);
  assign kif.done         = done_q;
  assign kif.parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: unbuffered and buffered instances driven in lockstep,
// accepted subkeys collected per instance and compared against the classic DES example.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123457799BBCDFF1;
  localparam int unsigned DEPTH = 512;

  localparam logic [47:0] EK [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode, abort, ready;
  logic [63:0] key;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_key_if if0 ();
  des_key_if if1 ();

  assign if0.start = start;  assign if0.mode = mode;  assign if0.key_in = key;
  assign if0.abort = abort;  assign if0.subkey_ready = ready;
  assign if1.start = start;  assign if1.mode = mode;  assign if1.key_in = key;
  assign if1.abort = abort;  assign if1.subkey_ready = ready;

  des_key_schedule #(.PIPE_OUT(1'b0)) u_dut0 (.clk(clk), .rst(rst), .kif(if0));
  des_key_schedule #(.PIPE_OUT(1'b1)) u_dut1 (.clk(clk), .rst(rst), .kif(if1));

  logic        vld  [2];
  logic [47:0] sk   [2];
  logic [3:0]  idx  [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        perr [2];

  assign vld[0] = if0.subkey_valid;  assign vld[1] = if1.subkey_valid;
  assign sk[0]  = if0.subkey;        assign sk[1]  = if1.subkey;
  assign idx[0] = if0.round_idx;     assign idx[1] = if1.round_idx;
  assign bsy[0] = if0.busy;          assign bsy[1] = if1.busy;
  assign dn[0]  = if0.done;          assign dn[1]  = if1.done;
  assign perr[0] = if0.parity_err;   assign perr[1] = if1.parity_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [47:0] got_key  [2][DEPTH];
  logic [3:0]  got_idx  [2][DEPTH];
  int          n        [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          last_acc [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  int          base_n   [2] = '{0, 0};
  int          base_dn  [2] = '{0, 0};
  logic        stall    [2] = '{1'b0, 1'b0};
  logic [47:0] hold_key [2];
  logic [3:0]  hold_idx [2];

  // Inputs change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stall[d] = 1'b0;
      end else begin
        if (stall[d]) begin
          chk($sformatf("stall_key%0d", d), 64'(sk[d]), 64'(hold_key[d]));
          chk($sformatf("stall_idx%0d", d), 64'(idx[d]), 64'(hold_idx[d]));
        end
        if (vld[d] && ready && !abort) begin
          if (n[d] < DEPTH) begin
            got_key[d][n[d]] = sk[d];
            got_idx[d][n[d]] = idx[d];
          end
          n[d]++;
          last_acc[d] = cyc;
        end
        if (dn[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
          chk($sformatf("done_busy%0d", d), 64'(bsy[d]), 64'd0);
          chk($sformatf("done_vld%0d", d), 64'(vld[d]), 64'd0);
        end
        stall[d]    = vld[d] && !ready && !abort;
        hold_key[d] = sk[d];
        hold_idx[d] = idx[d];
      end
    end
  end

  // Start is held across exactly one edge; returns just after that edge.
  task automatic start_sched(input logic [63:0] k, input logic m);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      base_n[d]  = n[d];
      base_dn[d] = done_cnt[d];
    end
    key = k; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int c = 0; c < budget; c++) begin
      if (done_cnt[0] > base_dn[0] && done_cnt[1] > base_dn[1]) break;
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", 64'(done_cnt[0] > base_dn[0] && done_cnt[1] > base_dn[1]), 64'd1);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input logic m, input int cnt0, input int cnt1, input bit zero);
    int cnt;
    logic [47:0] exp;
    for (int d = 0; d < 2; d++) begin
      cnt = (d == 0) ? cnt0 : cnt1;
      chk($sformatf("count%0d", d), 64'(n[d] - base_n[d]), 64'(cnt));
      for (int i = 0; i < cnt && i < n[d] - base_n[d] && base_n[d] + i < DEPTH; i++) begin
        exp = zero ? 48'h0 : (m ? EK[15 - i] : EK[i]);
        chk($sformatf("idx%0d_%0d", d, i), 64'(got_idx[d][base_n[d] + i]), 64'(i));
        chk($sformatf("key%0d_%0d", d, i), 64'(got_key[d][base_n[d] + i]), 64'(exp));
      end
    end
  endtask

  task automatic check_done_pulse();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("done_once%0d", d), 64'(done_cnt[d] - base_dn[d]), 64'd1);
      chk($sformatf("done_lat%0d", d), 64'(done_cyc[d] - last_acc[d]), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; abort = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_vld%0d", d), 64'(vld[d]), 64'd0);
      chk($sformatf("rst_key%0d", d), 64'(sk[d]), 64'd0);
      chk($sformatf("rst_idx%0d", d), 64'(idx[d]), 64'd0);
      chk($sformatf("rst_busy%0d", d), 64'(bsy[d]), 64'd0);
      chk($sformatf("rst_done%0d", d), 64'(dn[d]), 64'd0);
      chk($sformatf("rst_perr%0d", d), 64'(perr[d]), 64'd0);
    end
    @(negedge clk) rst = 1'b0;
    ready = 1'b1;

    // Encrypt order, ready held high, plus first-subkey latency of each variant.
    start_sched(KEY_A, 1'b0);
    chk("enc_vld0_t1", 64'(vld[0]), 64'd1);
    chk("enc_vld1_t1", 64'(vld[1]), 64'd0);
    chk("enc_busy0", 64'(bsy[0]), 64'd1);
    chk("enc_busy1", 64'(bsy[1]), 64'd1);
    chk("enc_first0", 64'(sk[0]), 64'(EK[0]));
    chk("enc_idx0", 64'(idx[0]), 64'd0);
    @(posedge clk); #1;
    chk("enc_vld1_t2", 64'(vld[1]), 64'd1);
    chk("enc_first1", 64'(sk[1]), 64'(EK[0]));
    wait_done(60, 1'b0);
    check_run(1'b0, 16, 16, 1'b0);
    check_done_pulse();
    chk("enc_perr0", 64'(perr[0]), 64'd0);
    chk("enc_perr1", 64'(perr[1]), 64'd0);

    // Decrypt order.
    start_sched(KEY_A, 1'b1);
    chk("dec_first0", 64'(sk[0]), 64'(EK[15]));
    wait_done(60, 1'b0);
    check_run(1'b1, 16, 16, 1'b0);
    check_done_pulse();

    // Random backpressure in both orders.
    start_sched(KEY_A, 1'b0);
    wait_done(300, 1'b1);
    check_run(1'b0, 16, 16, 1'b0);
    check_done_pulse();
    start_sched(KEY_A, 1'b1);
    wait_done(300, 1'b1);
    check_run(1'b1, 16, 16, 1'b0);
    check_done_pulse();

    // Even-parity first byte: flagged, schedule unaffected (parity bit is dropped by PC-1).
    start_sched(KEY_P, 1'b1);
    wait_done(60, 1'b0);
    check_run(1'b1, 16, 16, 1'b0);
    chk("par_perr0", 64'(perr[0]), 64'd1);
    chk("par_perr1", 64'(perr[1]), 64'd1);

    // Abort after 5 accepts on the unbuffered instance; abort coincides with an accept.
    start_sched(KEY_A, 1'b0);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy0", 64'(bsy[0]), 64'd0);
    chk("abort_busy1", 64'(bsy[1]), 64'd0);
    chk("abort_vld0", 64'(vld[0]), 64'd0);
    chk("abort_vld1", 64'(vld[1]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_run(1'b0, 5, 4, 1'b0);
    chk("abort_nodone0", 64'(done_cnt[0] - base_dn[0]), 64'd0);
    chk("abort_nodone1", 64'(done_cnt[1] - base_dn[1]), 64'd0);

    // All-zero key after abort.
    start_sched(64'h0, 1'b0);
    wait_done(60, 1'b0);
    check_run(1'b0, 16, 16, 1'b1);
    chk("zero_perr0", 64'(perr[0]), 64'd1);

    // Start while busy is ignored (stalled at round 1).
    ready = 1'b0;
    start_sched(KEY_A, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    key = 64'h0; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_key0", 64'(sk[0]), 64'(EK[0]));
    chk("ign_idx0", 64'(idx[0]), 64'd0);
    chk("ign_key1", 64'(sk[1]), 64'(EK[0]));
    chk("ign_perr0", 64'(perr[0]), 64'd0);
    chk("ign_perr1", 64'(perr[1]), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ready = 1'b1;

    // Reset asserted mid-schedule while serving cipher round 7.
    start_sched(KEY_A, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (idx[0] == 4'd6) break;
    end
    chk("rst_mid_round", 64'(idx[0]), 64'd6);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_vld%0d", d), 64'(vld[d]), 64'd0);
      chk($sformatf("mid_key%0d", d), 64'(sk[d]), 64'd0);
      chk($sformatf("mid_idx%0d", d), 64'(idx[d]), 64'd0);
      chk($sformatf("mid_busy%0d", d), 64'(bsy[d]), 64'd0);
      chk($sformatf("mid_done%0d", d), 64'(dn[d]), 64'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("mid_nodone0", 64'(done_cnt[0] - base_dn[0]), 64'd0);

    // Start presented in the done cycle is taken (buffered instance is still busy then).
    start_sched(KEY_A, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn[0]) break;
    end
    chk("dc_done_seen", 64'(dn[0]), 64'd1);
    key = 64'h0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dc_busy0", 64'(bsy[0]), 64'd1);
    chk("dc_idx0", 64'(idx[0]), 64'd0);
    chk("dc_perr0", 64'(perr[0]), 64'd1);
    chk("dc_perr1", 64'(perr[1]), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("dc_abort_busy0", 64'(bsy[0]), 64'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
